// File: rtl/controlador_display_7_segmentos_if.sv
// Display bus for the 4-digit multiplexed 7-segment driver.
// Carries the four hex nibbles into the driver and the active-low pin
// drives back out toward the board.
interface controlador_display_7_segmentos_if;
  logic [3:0] i_Datos_0;
  logic [3:0] i_Datos_1;
  logic [3:0] i_Datos_2;
  logic [3:0] i_Datos_3;
  logic [6:0] o_Segmentos;
  logic [3:0] o_Anodo_4_Bits;

  // Side that produces the digit values and watches the pins
  modport master (
    output i_Datos_0,
    output i_Datos_1,
    output i_Datos_2,
    output i_Datos_3,
    input  o_Segmentos,
    input  o_Anodo_4_Bits
  );

  // Side that scans the digits and drives the pins
  modport slave (
    input  i_Datos_0,
    input  i_Datos_1,
    input  i_Datos_2,
    input  i_Datos_3,
    output o_Segmentos,
    output o_Anodo_4_Bits
  );
endinterface

// File: rtl/controlador_display_7_segmentos.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler sets how long each digit stays lit; a 2-bit digit index
// walks 0..3. The anode and segment pins are registered from the index
// value before each edge, so the pins lag the index by one clock.
// All pin drives are active-low.
module controlador_display_7_segmentos #(
  parameter int CICLOS_POR_DIGITO = 100000
) (
  input logic                              i_Reloj,
  input logic                              i_Reset,
  controlador_display_7_segmentos_if.slave io_Display
);

  localparam logic [23:0] LP_ULTIMA_CUENTA = 24'(CICLOS_POR_DIGITO - 1);

  typedef enum logic [1:0] {
    DIGITO_0 = 2'd0,
    DIGITO_1 = 2'd1,
    DIGITO_2 = 2'd2,
    DIGITO_3 = 2'd3
  } t_digito;

  t_digito     r_Digito;
  t_digito     w_Digito_Siguiente;
  logic [23:0] r_Prescaler;
  logic [23:0] w_Prescaler_Siguiente;
  logic        w_Fin_Periodo;
  logic [3:0]  w_Nibble_Activo;
  logic [3:0]  w_Anodo_Decod;
  logic [6:0]  w_Segmentos_Decod;
  logic [3:0]  r_Anodo;
  logic [6:0]  r_Segmentos;

  // Prescaler wraps to zero on the last count of each dwell period
  always_comb begin
    w_Fin_Periodo         = 1'b0;
    w_Prescaler_Siguiente = r_Prescaler + 24'd1;
    if (r_Prescaler == LP_ULTIMA_CUENTA) begin
      w_Fin_Periodo         = 1'b1;
      w_Prescaler_Siguiente = 24'd0;
    end
  end

  // Next digit: advance round-robin only when the dwell period ends
  always_comb begin
    w_Digito_Siguiente = r_Digito;
    if (w_Fin_Periodo) begin
      case (r_Digito)
        DIGITO_0: w_Digito_Siguiente = DIGITO_1;
        DIGITO_1: w_Digito_Siguiente = DIGITO_2;
        DIGITO_2: w_Digito_Siguiente = DIGITO_3;
        DIGITO_3: w_Digito_Siguiente = DIGITO_0;
        default:  w_Digito_Siguiente = DIGITO_0;
      endcase
    end
  end

  // Prescaler and digit index registers
  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Prescaler <= 24'd0;
      r_Digito    <= DIGITO_0;
    end else begin
      r_Prescaler <= w_Prescaler_Siguiente;
      r_Digito    <= w_Digito_Siguiente;
    end
  end

  // Pick the active digit's nibble and its one-cold anode pattern
  always_comb begin
    w_Nibble_Activo = io_Display.i_Datos_0;
    w_Anodo_Decod   = 4'b1111;
    case (r_Digito)
      DIGITO_0: begin
        w_Nibble_Activo = io_Display.i_Datos_0;
        w_Anodo_Decod   = 4'b1110;
      end
      DIGITO_1: begin
        w_Nibble_Activo = io_Display.i_Datos_1;
        w_Anodo_Decod   = 4'b1101;
      end
      DIGITO_2: begin
        w_Nibble_Activo = io_Display.i_Datos_2;
        w_Anodo_Decod   = 4'b1011;
      end
      DIGITO_3: begin
        w_Nibble_Activo = io_Display.i_Datos_3;
        w_Anodo_Decod   = 4'b0111;
      end
      default: begin
        w_Nibble_Activo = 4'h0;
        w_Anodo_Decod   = 4'b1111;
      end
    endcase
  end

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    w_Segmentos_Decod = 7'b1111111;
    case (w_Nibble_Activo)
      4'h0:    w_Segmentos_Decod = 7'b1000000;
      4'h1:    w_Segmentos_Decod = 7'b1111001;
      4'h2:    w_Segmentos_Decod = 7'b0100100;
      4'h3:    w_Segmentos_Decod = 7'b0110000;
      4'h4:    w_Segmentos_Decod = 7'b0011001;
      4'h5:    w_Segmentos_Decod = 7'b0010010;
      4'h6:    w_Segmentos_Decod = 7'b0000010;
      4'h7:    w_Segmentos_Decod = 7'b1111000;
      4'h8:    w_Segmentos_Decod = 7'b0000000;
      4'h9:    w_Segmentos_Decod = 7'b0010000;
      4'hA:    w_Segmentos_Decod = 7'b0001000;
      4'hB:    w_Segmentos_Decod = 7'b0000011;
      4'hC:    w_Segmentos_Decod = 7'b1000110;
      4'hD:    w_Segmentos_Decod = 7'b0100001;
      4'hE:    w_Segmentos_Decod = 7'b0000110;
      4'hF:    w_Segmentos_Decod = 7'b0001110;
      default: w_Segmentos_Decod = 7'b1111111;
    endcase
  end

  // Pin registers: all-off in reset, otherwise refreshed every edge
  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Anodo     <= 4'b1111;
      r_Segmentos <= 7'b1111111;
    end else begin
      r_Anodo     <= w_Anodo_Decod;
      r_Segmentos <= w_Segmentos_Decod;
    end
  end

  assign io_Display.o_Anodo_4_Bits = r_Anodo;
  assign io_Display.o_Segmentos    = r_Segmentos;

endmodule

// File: tb/tb_controlador_display_7_segmentos.sv
// Directed bench for the 7-segment scan driver: one fast instance
// (one clock per digit) and one slow instance (four clocks per digit).
module tb_controlador_display_7_segmentos;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [6:0] tablaSeg [0:15];
  logic [3:0] tablaAnodo [0:3];
  logic [6:0] segDatos [0:3];

  controlador_display_7_segmentos_if busRapido ();
  controlador_display_7_segmentos_if busLento ();

  controlador_display_7_segmentos #(.CICLOS_POR_DIGITO(1)) dutRapido (
    .i_Reloj    (clk),
    .i_Reset    (rst_n),
    .io_Display (busRapido)
  );

  controlador_display_7_segmentos #(.CICLOS_POR_DIGITO(4)) dutLento (
    .i_Reloj    (clk),
    .i_Reset    (rst_n),
    .io_Display (busLento)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse reset for one clock; release lands on a falling edge
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL reset_anodo_rapido got=%b exp=1111", busRapido.o_Anodo_4_Bits);
    end
    checks++;
    if (busRapido.o_Segmentos !== 7'b1111111) begin
      failures++;
      $display("[TB] FAIL reset_seg_rapido got=%b exp=1111111", busRapido.o_Segmentos);
    end
    checks++;
    if (busLento.o_Anodo_4_Bits !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL reset_anodo_lento got=%b exp=1111", busLento.o_Anodo_4_Bits);
    end
    checks++;
    if (busLento.o_Segmentos !== 7'b1111111) begin
      failures++;
      $display("[TB] FAIL reset_seg_lento got=%b exp=1111111", busLento.o_Segmentos);
    end
    // Asynchronous assertion between edges
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL pre_async_anodo got=%b exp=1101", busRapido.o_Anodo_4_Bits);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL async_anodo got=%b exp=1111", busRapido.o_Anodo_4_Bits);
    end
    checks++;
    if (busRapido.o_Segmentos !== 7'b1111111) begin
      failures++;
      $display("[TB] FAIL async_seg got=%b exp=1111111", busRapido.o_Segmentos);
    end
  endtask

  task automatic test_scan_order();
    $display("[TB] test_scan_order");
    applyReset();
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busRapido.o_Anodo_4_Bits !== tablaAnodo[k % 4]) begin
        failures++;
        $display("[TB] FAIL scan_anodo edge=%0d got=%b exp=%b", k + 1,
                 busRapido.o_Anodo_4_Bits, tablaAnodo[k % 4]);
      end
      checks++;
      if (busRapido.o_Segmentos !== segDatos[k % 4]) begin
        failures++;
        $display("[TB] FAIL scan_seg edge=%0d got=%b exp=%b", k + 1,
                 busRapido.o_Segmentos, segDatos[k % 4]);
      end
    end
  endtask

  task automatic test_dwell();
    $display("[TB] test_dwell");
    applyReset();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (busLento.o_Anodo_4_Bits !== tablaAnodo[(k / 4) % 4]) begin
        failures++;
        $display("[TB] FAIL dwell_anodo edge=%0d got=%b exp=%b", k + 1,
                 busLento.o_Anodo_4_Bits, tablaAnodo[(k / 4) % 4]);
      end
      checks++;
      if (busLento.o_Segmentos !== segDatos[(k / 4) % 4]) begin
        failures++;
        $display("[TB] FAIL dwell_seg edge=%0d got=%b exp=%b", k + 1,
                 busLento.o_Segmentos, segDatos[(k / 4) % 4]);
      end
    end
  endtask

  task automatic test_decode_sweep();
    $display("[TB] test_decode_sweep");
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      rst_n = 1'b0;
      busRapido.i_Datos_0 = 4'(v);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busRapido.o_Anodo_4_Bits !== 4'b1110) begin
        failures++;
        $display("[TB] FAIL sweep_anodo code=%h got=%b exp=1110", v, busRapido.o_Anodo_4_Bits);
      end
      checks++;
      if (busRapido.o_Segmentos !== tablaSeg[v]) begin
        failures++;
        $display("[TB] FAIL sweep_seg code=%h got=%b exp=%b", v,
                 busRapido.o_Segmentos, tablaSeg[v]);
      end
    end
    busRapido.i_Datos_0 = 4'h1;
  endtask

  task automatic test_live_change();
    $display("[TB] test_live_change");
    applyReset();
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busLento.o_Anodo_4_Bits !== 4'b1011 || busLento.o_Segmentos !== 7'b0110000) begin
      failures++;
      $display("[TB] FAIL live_before got=%b/%b exp=1011/0110000",
               busLento.o_Anodo_4_Bits, busLento.o_Segmentos);
    end
    @(negedge clk);
    busLento.i_Datos_2 = 4'hE;
    @(posedge clk);
    #1;
    checks++;
    if (busLento.o_Anodo_4_Bits !== 4'b1011 || busLento.o_Segmentos !== 7'b0000110) begin
      failures++;
      $display("[TB] FAIL live_after got=%b/%b exp=1011/0000110",
               busLento.o_Anodo_4_Bits, busLento.o_Segmentos);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busLento.o_Anodo_4_Bits !== 4'b0111 || busLento.o_Segmentos !== 7'b0011001) begin
      failures++;
      $display("[TB] FAIL live_digit3 got=%b/%b exp=0111/0011001",
               busLento.o_Anodo_4_Bits, busLento.o_Segmentos);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busLento.o_Anodo_4_Bits !== 4'b1110 || busLento.o_Segmentos !== 7'b1111001) begin
      failures++;
      $display("[TB] FAIL live_digit0 got=%b/%b exp=1110/1111001",
               busLento.o_Anodo_4_Bits, busLento.o_Segmentos);
    end
    busLento.i_Datos_2 = 4'h3;
  endtask

  task automatic test_mid_scan_reset();
    $display("[TB] test_mid_scan_reset");
    applyReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL mid_pre_anodo got=%b exp=1101", busRapido.o_Anodo_4_Bits);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1111 || busRapido.o_Segmentos !== 7'b1111111) begin
      failures++;
      $display("[TB] FAIL mid_async got=%b/%b exp=1111/1111111",
               busRapido.o_Anodo_4_Bits, busRapido.o_Segmentos);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1111 || busRapido.o_Segmentos !== 7'b1111111) begin
      failures++;
      $display("[TB] FAIL mid_hold got=%b/%b exp=1111/1111111",
               busRapido.o_Anodo_4_Bits, busRapido.o_Segmentos);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1110 || busRapido.o_Segmentos !== 7'b1111001) begin
      failures++;
      $display("[TB] FAIL mid_restart got=%b/%b exp=1110/1111001",
               busRapido.o_Anodo_4_Bits, busRapido.o_Segmentos);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busRapido.o_Anodo_4_Bits !== 4'b1101 || busRapido.o_Segmentos !== 7'b0100100) begin
      failures++;
      $display("[TB] FAIL mid_next got=%b/%b exp=1101/0100100",
               busRapido.o_Anodo_4_Bits, busRapido.o_Segmentos);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    tablaSeg[0]  = 7'b1000000; tablaSeg[1]  = 7'b1111001;
    tablaSeg[2]  = 7'b0100100; tablaSeg[3]  = 7'b0110000;
    tablaSeg[4]  = 7'b0011001; tablaSeg[5]  = 7'b0010010;
    tablaSeg[6]  = 7'b0000010; tablaSeg[7]  = 7'b1111000;
    tablaSeg[8]  = 7'b0000000; tablaSeg[9]  = 7'b0010000;
    tablaSeg[10] = 7'b0001000; tablaSeg[11] = 7'b0000011;
    tablaSeg[12] = 7'b1000110; tablaSeg[13] = 7'b0100001;
    tablaSeg[14] = 7'b0000110; tablaSeg[15] = 7'b0001110;

    tablaAnodo[0] = 4'b1110; tablaAnodo[1] = 4'b1101;
    tablaAnodo[2] = 4'b1011; tablaAnodo[3] = 4'b0111;

    // Segment patterns for data 1,2,3,4 on digits 0..3
    segDatos[0] = 7'b1111001; segDatos[1] = 7'b0100100;
    segDatos[2] = 7'b0110000; segDatos[3] = 7'b0011001;

    busRapido.i_Datos_0 = 4'h1; busRapido.i_Datos_1 = 4'h2;
    busRapido.i_Datos_2 = 4'h3; busRapido.i_Datos_3 = 4'h4;
    busLento.i_Datos_0  = 4'h1; busLento.i_Datos_1  = 4'h2;
    busLento.i_Datos_2  = 4'h3; busLento.i_Datos_3  = 4'h4;

    test_reset();
    test_scan_order();
    test_dwell();
    test_decode_sweep();
    test_live_change();
    test_mid_scan_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
